// File: rtl/cordic_host_if.sv
// Host-side initiator for the CORDIC core start/done handshake.
// Takes one job over a valid/ready request channel and returns the captured result or a timeout error.
module cordic_host_if #(
  parameter int unsigned TIMEOUT_CYCLES = 32
) (
  input  logic       clka,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_mode,
  input  logic [7:0] req_op0,
  input  logic [7:0] req_op1,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_res0,
  output logic [7:0] resp_res1,
  output logic       resp_err,
  output logic       start,
  output logic       cordic_mode,
  output logic [7:0] in_port0,
  output logic [7:0] in_port1,
  input  logic [7:0] out_port0,
  input  logic [7:0] out_port1,
  input  logic       done
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic          req_ready_q, req_ready_d;
  logic          start_q, start_d;
  logic          mode_q, mode_d;
  logic [DW-1:0] op0_q, op0_d;
  logic [DW-1:0] op1_q, op1_d;
  logic          resp_valid_q, resp_valid_d;
  logic [DW-1:0] res0_q, res0_d;
  logic [DW-1:0] res1_q, res1_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;

  // Next-state and next-output logic; every register holds unless a state moves it.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    start_d      = start_q;
    mode_d       = mode_q;
    op0_d        = op0_q;
    op1_d        = op1_q;
    resp_valid_d = resp_valid_q;
    res0_d       = res0_q;
    res1_d       = res1_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    armed_d      = armed_q;

    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          mode_d      = req_mode;
          op0_d       = req_op0;
          op1_d       = req_op1;
          req_ready_d = 1'b0;
          start_d     = 1'b1;
          state_d     = START;
        end
      end
      START: begin
        start_d = 1'b0;
        cnt_d   = '0;
        armed_d = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
        // done only counts once it has been seen low in this job, masking a stale level
        if (!done) begin
          armed_d = 1'b1;
        end
        if (done && armed_q) begin
          res0_d       = out_port0;
          res1_d       = out_port1;
          err_d        = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end else if (cnt_q >= CNT_LAST) begin
          res0_d       = '0;
          res1_d       = '0;
          err_d        = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      start_q      <= 1'b0;
      mode_q       <= 1'b0;
      op0_q        <= '0;
      op1_q        <= '0;
      resp_valid_q <= 1'b0;
      res0_q       <= '0;
      res1_q       <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      start_q      <= start_d;
      mode_q       <= mode_d;
      op0_q        <= op0_d;
      op1_q        <= op1_d;
      resp_valid_q <= resp_valid_d;
      res0_q       <= res0_d;
      res1_q       <= res1_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      armed_q      <= armed_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign start       = start_q;
  assign cordic_mode = mode_q;
  assign in_port0    = op0_q;
  assign in_port1    = op1_q;
  assign resp_valid  = resp_valid_q;
  assign resp_res0   = res0_q;
  assign resp_res1   = res1_q;
  assign resp_err    = err_q;

endmodule

// File: tb/tb_cordic_host_if.sv
// Scoreboard bench for cordic_host_if with a behavioural CORDIC core model.
// Expected responses come from the job's done timing rule; a negedge monitor compares them.
module tb_cordic_host_if;

  localparam int unsigned T = 32;

  logic       clka = 1'b0;
  logic       reset_n = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_mode = 1'b0;
  logic [7:0] req_op0 = '0;
  logic [7:0] req_op1 = '0;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  logic [7:0] resp_res0;
  logic [7:0] resp_res1;
  logic       resp_err;
  logic       start;
  logic       cordic_mode;
  logic [7:0] in_port0;
  logic [7:0] in_port1;
  logic [7:0] out_port0 = '0;
  logic [7:0] out_port1 = '0;
  logic       done = 1'b0;

  cordic_host_if #(.TIMEOUT_CYCLES(T)) dut (
    .clka(clka), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_op0(req_op0), .req_op1(req_op1),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_res0(resp_res0), .resp_res1(resp_res1), .resp_err(resp_err),
    .start(start), .cordic_mode(cordic_mode),
    .in_port0(in_port0), .in_port1(in_port1),
    .out_port0(out_port0), .out_port1(out_port1), .done(done)
  );

  always #5 clka = ~clka;

  // s: done forced high for the first s cycles after start; d: done high from cycle d on (0 = never)
  typedef struct {
    logic       mode;
    logic [7:0] op0, op1, out0, out1;
    int         s;
    int         d;
  } job_t;

  typedef struct {
    logic       mode;
    logic [7:0] op0, op1, res0, res1;
    logic       err;
    int         lat;
  } exp_t;

  job_t core_q[$];
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   bp_left = 0;
  int   n_resp = 0;
  int   starts = 0;
  int   start_cyc = 0;
  logic in_resp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic job_t mk(input logic m, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] o0, input logic [7:0] o1,
                              input int s, input int d);
    job_t j;
    j.mode = m; j.op0 = a; j.op1 = b; j.out0 = o0; j.out1 = o1; j.s = s; j.d = d;
    return j;
  endfunction

  // Reference: a job succeeds iff done rises after having been low and no later than cycle T-1 of WAIT.
  function automatic exp_t model(input job_t j);
    exp_t e;
    bit   ok;
    ok     = (j.d != 0) && (j.d > j.s) && (j.d <= int'(T) - 1);
    e.mode = j.mode;
    e.op0  = j.op0;
    e.op1  = j.op1;
    e.err  = !ok;
    e.res0 = ok ? j.out0 : 8'h00;
    e.res1 = ok ? j.out1 : 8'h00;
    e.lat  = ok ? j.d + 2 : int'(T) + 1;
    return e;
  endfunction

  function automatic logic done_at(input job_t j, input int k);
    return (k < j.s) || (j.d != 0 && k >= j.d);
  endfunction

  always @(posedge clka) cyc <= cyc + 1;

  // Core model: done is a level that stays high after completion until the next start.
  job_t cur;
  int   tj = 0;
  logic active = 1'b0;
  always @(posedge clka) begin
    if (start && core_q.size() > 0) begin
      done <= done_at(core_q[0], 0);
      if (!done_at(core_q[0], 0)) begin
        out_port0 <= 8'($urandom);
        out_port1 <= 8'($urandom);
      end
      cur    <= core_q.pop_front();
      tj     <= 1;
      active <= 1'b1;
    end else if (active) begin
      done <= done_at(cur, tj);
      if (cur.d != 0 && tj >= cur.d) begin
        out_port0 <= cur.out0;
        out_port1 <= cur.out1;
      end else if (!done_at(cur, tj)) begin
        out_port0 <= 8'($urandom);
        out_port1 <= 8'($urandom);
      end
      if (tj < 1000) tj <= tj + 1;
    end
  end

  // Consumer: random resp_ready, with optional forced backpressure while a response is shown.
  initial begin
    forever begin
      @(posedge clka);
      #2;
      if (resp_valid && bp_left > 0) begin
        resp_ready = 1'b0;
        bp_left--;
      end else begin
        resp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: operand stability, response contents, latency and single start per job.
  always @(negedge clka) begin
    if (!reset_n) begin
      starts  <= 0;
      in_resp <= 1'b0;
    end else begin
      if (start) begin
        starts    <= starts + 1;
        start_cyc <= cyc;
      end
      if (exp_q.size() > 0) begin
        chk("op_mode", 32'(cordic_mode), 32'(exp_q[0].mode));
        chk("op_in0", 32'(in_port0), 32'(exp_q[0].op0));
        chk("op_in1", 32'(in_port1), 32'(exp_q[0].op1));
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_resp", 32'(resp_valid), 32'(0));
        end else begin
          chk("resp_res0", 32'(resp_res0), 32'(exp_q[0].res0));
          chk("resp_res1", 32'(resp_res1), 32'(exp_q[0].res1));
          chk("resp_err", 32'(resp_err), 32'(exp_q[0].err));
          chk("req_ready_in_resp", 32'(req_ready), 32'(0));
          if (!in_resp) begin
            chk("latency", 32'(cyc - start_cyc), 32'(exp_q[0].lat));
            chk("start_count", 32'(starts), 32'(1));
            starts  <= 0;
            in_resp <= 1'b1;
          end
          if (resp_ready) begin
            void'(exp_q.pop_front());
            in_resp <= 1'b0;
            hs_cyc  <= cyc;
            n_resp  <= n_resp + 1;
          end
        end
      end
    end
  end

  task automatic send_job(input job_t j, input bit expect_resp, output int acc_cyc);
    core_q.push_back(j);
    @(negedge clka);
    req_valid = 1'b1;
    req_mode  = j.mode;
    req_op0   = j.op0;
    req_op1   = j.op1;
    acc_cyc   = -1;
    for (int i = 0; i < 400; i++) begin
      if (req_ready) begin
        acc_cyc = cyc;
        break;
      end
      @(negedge clka);
    end
    if (acc_cyc < 0) begin
      chk("accept_timeout", 32'(req_ready), 32'(1));
      req_valid = 1'b0;
      return;
    end
    @(posedge clka);
    if (expect_resp) exp_q.push_back(model(j));
    #1;
    req_valid = 1'b0;
    req_mode  = 1'($urandom);
    req_op0   = 8'($urandom);
    req_op1   = 8'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(negedge clka);
    if (exp_q.size() > 0) begin
      chk("drain_timeout", 32'(exp_q.size()), 32'(0));
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_ready", 32'(req_ready), 32'(1));
    chk("rst_start", 32'(start), 32'(0));
    chk("rst_mode", 32'(cordic_mode), 32'(0));
    chk("rst_in0", 32'(in_port0), 32'(0));
    chk("rst_in1", 32'(in_port1), 32'(0));
    chk("rst_resp_valid", 32'(resp_valid), 32'(0));
    chk("rst_res0", 32'(resp_res0), 32'(0));
    chk("rst_res1", 32'(resp_res1), 32'(0));
    chk("rst_err", 32'(resp_err), 32'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc;
    int acc2;
    int r0;
    job_t j;
    int s;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clka);
    #1 check_reset_outputs();
    @(negedge clka) reset_n = 1'b1;

    // single job, then stale done, then timeout
    send_job(mk(1'b0, 8'd10, 8'd0, 8'h3C, 8'h05, 1, 12), 1'b1, acc);
    drain();
    send_job(mk(1'b1, 8'h22, 8'h33, 8'hA1, 8'h5A, 2, 8), 1'b1, acc);
    drain();
    send_job(mk(1'b0, 8'd7, 8'd9, 8'hFF, 8'hEE, 0, 0), 1'b1, acc);
    drain();

    // done on the last WAIT cycle wins; one cycle later is a timeout
    send_job(mk(1'b1, 8'h40, 8'h41, 8'h12, 8'h34, 0, int'(T) - 1), 1'b1, acc);
    drain();
    send_job(mk(1'b0, 8'h50, 8'h51, 8'h56, 8'h78, 0, int'(T)), 1'b1, acc);
    drain();

    // backpressure with a second request waiting
    bp_left = 5;
    j = mk(1'b1, 8'h61, 8'h62, 8'h9A, 8'hBC, 0, 4);
    send_job(j, 1'b1, acc);
    send_job(mk(1'b0, 8'h71, 8'h72, 8'hDE, 8'hF0, 0, 3), 1'b1, acc2);
    chk("accept_after_resp", 32'(acc2), 32'(hs_cyc + 1));
    chk("bp_held", 32'(acc2 - acc >= model(j).lat + 7), 32'(1));
    drain();

    // reset in WAIT cycle 4
    send_job(mk(1'b1, 8'h05, 8'h06, 8'h11, 8'h22, 0, 20), 1'b0, acc);
    repeat (4) @(posedge clka);
    #1 reset_n = 1'b0;
    #1 check_reset_outputs();
    @(negedge clka);
    @(negedge clka) reset_n = 1'b1;
    repeat (40) @(negedge clka);
    send_job(mk(1'b0, 8'h0A, 8'h0B, 8'h77, 8'h88, 0, 5), 1'b1, acc);
    drain();

    // back-to-back jobs
    r0 = n_resp;
    for (int i = 0; i < 4; i++) begin
      send_job(mk(1'(i % 2), 8'(i + 1), 8'(i * 16), 8'(8'hC0 + i), 8'(8'h30 + i), 0, 3 + i),
               1'b1, acc);
    end
    drain();
    chk("b2b_count", 32'(n_resp - r0), 32'(4));

    // randomized jobs
    for (int i = 0; i < 24; i++) begin
      s = int'($urandom_range(0, 2));
      j = mk(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), s,
             ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(s + 1, 34)));
      send_job(j, 1'b1, acc);
    end
    drain();
    repeat (5) @(negedge clka);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
